stream_mac: RTL and testbench
=============================

STREAM_MAC -- requirements
Module: stream_mac

Interface
REQ-001 Parameter W, 16: signed element width of both input streams and of m_data.
REQ-002 Parameter LGK, 7: width of k_len; max dot-product length 2^LGK-1.
REQ-003 Parameter ACC_W, 2*W+LGK: internal accumulator width, derived, never overridden.
REQ-004 clk  in  1: single clock, all state on rising edge.
REQ-005 rst_n  in  1: asynchronous active-low reset.
REQ-006 start  in  1: pulse; begins one dot product when in IDLE, ignored otherwise.
REQ-007 k_len  in  LGK: element count, sampled only on accepted start.
REQ-008 a_data/a_valid/a_ready  in/in/out  W/1/1: row-operand stream from upstream FIFO.
REQ-009 b_data/b_valid/b_ready  in/in/out  W/1/1: column-operand stream from upstream FIFO.
REQ-010 m_data/m_valid/m_ready  out/out/in  W/1/1: result stream, valid/ready.
REQ-011 busy  out  1: high in any state other than IDLE.

Function
REQ-012 FSM states IDLE, ACCUM, DRAIN, EMIT; reset state IDLE.
REQ-013 IDLE: start with k_len!=0 -> clear acc and element counter, latch k_len, go ACCUM; start with k_len==0 -> acc=0, go EMIT directly.
REQ-014 a_ready = b_ready = (state==ACCUM) && a_valid && b_valid; a pair is consumed only jointly (fire), never one stream alone.
REQ-015 Fire: signed product a_data*b_data (2W bits) registered in p_q with p_vld set next cycle; counter increments.
REQ-016 Cycle after p_vld: acc <= acc + sign-extended p_q; one product added per cycle, no bubbles required.
REQ-017 Fire with counter==k_len-1 -> go DRAIN; no further fires after the k_len-th.
REQ-018 DRAIN: lasts exactly until final product is accumulated (1 cycle), then EMIT with m_valid=1.
REQ-019 Latency: last fire at cycle t -> m_valid high at t+2.
REQ-020 EMIT: m_data constant while m_valid && !m_ready; on m_valid && m_ready -> m_valid=0, IDLE next cycle.
REQ-021 start asserted in same cycle as output handshake is ignored (state still EMIT).
REQ-022 Accumulator wraps modulo 2^ACC_W; cannot overflow for k_len<2^LGK.
REQ-023 m_data output conversion per REQ-026/027; computed combinationally from acc, registered only via acc.

Reset
REQ-024 rst_n low, any state, any cycle: state=IDLE, acc=0, p_q=0, p_vld=0, counter=0, m_valid=0, m_data=0, busy=0, a_ready=b_ready=0.
REQ-025 Reset mid-operation discards partial sum; no result emitted for the aborted dot product.

Configuration
REQ-026 Macro STREAM_MAC_SAT_EN defined: m_data = acc clamped to [-2^(W-1), 2^(W-1)-1].
REQ-027 Macro undefined: m_data = acc[W-1:0] (two's-complement wrap); no extra logic synthesised.

Structure
REQ-028 Package matmul_pkg holds the FSM state enum (mac_state_e), default W/LGK constants, and the saturate function.
REQ-029 One sub-module, mac_join, implements the two-stream join and product register (REQ-014/015); FSM, counter, accumulator stay in stream_mac.

Verification
REQ-030 k_len=4, A=1,2,3,4, B=5,6,7,8 both always valid, m_ready=1 -> m_data=70, m_valid one cycle, 2 cycles after 4th fire.
REQ-031 Same vectors, b_valid toggled 1/0 each cycle -> no fire while b_valid=0, a_ready low then; result 70.
REQ-032 k_len=2, A=-3,4, B=5,-2 with m_ready held 0 for 5 cycles -> m_data=-23 stable, busy=1, a_ready=0 throughout; released -> IDLE.
REQ-033 k_len=2, A=B=200,200 (sum 80000): with STREAM_MAC_SAT_EN m_data=32767; without m_data=16'h3880.
REQ-034 k_len=0 start -> m_data=0, m_valid next cycle, no input consumed.
REQ-035 rst_n pulsed low after 2 of 4 fires, then new start k_len=1, A=3, B=3 -> single result 9, no stale partial sum.

Source files
------------

// File: rtl/stream_mac_pkg.sv
// Shared types and constants for the streaming dot-product MAC.
// Holds the FSM state encoding, default widths and the output clamp helper.
package matmul_pkg;

    localparam int W_DEF   = 16;
    localparam int LGK_DEF = 7;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DRAIN = 2'd2,
        EMIT  = 2'd3
    } mac_state_e;

    // Clamp a sign-extended accumulator value into a w-bit signed range.
    function automatic logic signed [63:0] saturate(input logic signed [63:0] v, input int w);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (w - 1)) - 64'sd1;
        lo = -hi - 64'sd1;
        if (v > hi)      return hi;
        else if (v < lo) return lo;
        else             return v;
    endfunction

endpackage

// File: rtl/stream_mac_if.sv
// Operand (a, b) and result (m) valid/ready streams of stream_mac.
// slave is the MAC's view, master is the producer/consumer side.
interface stream_mac_if import matmul_pkg::*; #(
    parameter int W = W_DEF
);
    logic [W-1:0] a_data;
    logic         a_valid;
    logic         a_ready;
    logic [W-1:0] b_data;
    logic         b_valid;
    logic         b_ready;
    logic [W-1:0] m_data;
    logic         m_valid;
    logic         m_ready;

    modport master (
        output a_data, a_valid, b_data, b_valid, m_ready,
        input  a_ready, b_ready, m_data, m_valid
    );

    modport slave (
        input  a_data, a_valid, b_data, b_valid, m_ready,
        output a_ready, b_ready, m_data, m_valid
    );
endinterface

// File: rtl/stream_mac_join.sv
// Joins the a/b operand streams and registers their signed product; 1 cycle to p_vld.
// Both readies rise only when en and both valids are high, so neither stream moves alone.
module mac_join #(
    parameter int W = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en,
    input  logic signed [W-1:0]   a_data,
    input  logic                  a_valid,
    input  logic signed [W-1:0]   b_data,
    input  logic                  b_valid,
    output logic                  a_ready,
    output logic                  b_ready,
    output logic                  fire,
    output logic signed [2*W-1:0] p_q,
    output logic                  p_vld
);
    assign fire    = en && a_valid && b_valid;
    assign a_ready = fire;
    assign b_ready = fire;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p_q   <= '0;
            p_vld <= 1'b0;
        end else begin
            p_vld <= fire;
            if (fire) p_q <= (2*W)'(a_data) * (2*W)'(b_data);
        end
    end
endmodule

// File: rtl/stream_mac.sv
// Streaming signed dot product of k_len a/b pairs; result valid 2 cycles after the last pair.
// Result held until m_ready; STREAM_MAC_SAT_EN selects clamped output instead of low-bit wrap.
module stream_mac import matmul_pkg::*; #(
    parameter int W   = W_DEF,
    parameter int LGK = LGK_DEF
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           start,
    input  logic [LGK-1:0] k_len,
    output logic           busy,
    stream_mac_if.slave    str
);
    localparam int ACC_W = 2*W + LGK;

    mac_state_e              state;
    logic [LGK-1:0]          cnt;
    logic [LGK-1:0]          k_q;
    logic signed [ACC_W-1:0] acc;
    logic signed [2*W-1:0]   p_q;
    logic                    p_vld;
    logic                    fire;
    logic                    m_valid_q;

    mac_join #(.W(W)) u_join (
        .clk     (clk),
        .rst_n   (rst_n),
        .en      (state == ACCUM),
        .a_data  (str.a_data),
        .a_valid (str.a_valid),
        .b_data  (str.b_data),
        .b_valid (str.b_valid),
        .a_ready (str.a_ready),
        .b_ready (str.b_ready),
        .fire    (fire),
        .p_q     (p_q),
        .p_vld   (p_vld)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            k_q       <= '0;
            acc       <= '0;
            m_valid_q <= 1'b0;
        end else begin
            // p_vld is never high in IDLE, so the clear below cannot lose a product.
            if (p_vld) acc <= acc + {{LGK{p_q[2*W-1]}}, p_q};
            case (state)
                IDLE: begin
                    if (start) begin
                        acc <= '0;
                        cnt <= '0;
                        k_q <= k_len;
                        if (k_len == '0) begin
                            state     <= EMIT;
                            m_valid_q <= 1'b1;
                        end else begin
                            state <= ACCUM;
                        end
                    end
                end
                ACCUM: begin
                    if (fire) begin
                        cnt <= cnt + LGK'(1);
                        if (cnt == k_q - LGK'(1)) state <= DRAIN;
                    end
                end
                DRAIN: begin
                    state     <= EMIT;
                    m_valid_q <= 1'b1;
                end
                EMIT: begin
                    if (str.m_ready) begin
                        state     <= IDLE;
                        m_valid_q <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign busy        = (state != IDLE);
    assign str.m_valid = m_valid_q;

`ifdef STREAM_MAC_SAT_EN
    assign str.m_data = W'(saturate({{(64-ACC_W){acc[ACC_W-1]}}, acc}, W));
`else
    assign str.m_data = acc[W-1:0];
`endif

endmodule

// File: tb/tb_stream_mac.sv
// Randomised and directed bench for stream_mac against an arithmetic dot-product model.
module tb_stream_mac;
    localparam int W   = 16;
    localparam int LGK = 7;

    logic           clk;
    logic           rst_n;
    logic           start;
    logic [LGK-1:0] k_len;
    logic           busy;
    int             n_cmp;
    int             n_err;
    int             va[$];
    int             vb[$];

    stream_mac_if #(.W(W)) bus ();

    stream_mac #(.W(W), .LGK(LGK)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .k_len (k_len),
        .busy  (busy),
        .str   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Expected output word for an exact (unbounded) dot-product sum.
    function automatic logic [W-1:0] model_out(input longint s);
        longint hi;
        longint lo;
        hi = (longint'(1) <<< (W - 1)) - 1;
        lo = -hi - 1;
`ifdef STREAM_MAC_SAT_EN
        if (s > hi) s = hi;
        if (s < lo) s = lo;
`endif
        return s[W-1:0];
    endfunction

    task automatic pair(input int a, input int b);
        va.push_back(a);
        vb.push_back(b);
    endtask

    // Runs one dot product over va/vb; called and returns at a falling edge.
    task automatic run_dot(input int k, input int vpct, input bit tog_b, input int stall);
        longint      sum;
        int          fires;
        int          last;
        int          cyc;
        bit          got;
        bit          exp_rdy;
        logic [W-1:0] exp;
        sum   = 0;
        fires = 0;
        last  = 0;
        cyc   = 0;
        for (int i = 0; i < k; i++) sum += longint'(va[i]) * longint'(vb[i]);
        exp = model_out(sum);

        bus.m_ready = (stall == 0);
        bus.a_valid = 1'b1;
        bus.b_valid = 1'b1;
        start = 1'b1;
        k_len = LGK'(k);
        @(negedge clk);
        start = 1'b0;
        check("busy_after_start", 64'(busy), 64'(1));
        check("m_valid_after_start", 64'(bus.m_valid), 64'(k == 0));
        if (k == 0) check("k0_no_consume", 64'(bus.a_ready), 64'(0));
        got = bus.m_valid;

        while (!got && cyc < 400) begin
            bus.a_valid = ($urandom_range(99) < vpct);
            bus.b_valid = tog_b ? (cyc % 2 == 0) : ($urandom_range(99) < vpct);
            bus.a_data  = (fires < k) ? W'(va[fires]) : W'($urandom);
            bus.b_data  = (fires < k) ? W'(vb[fires]) : W'($urandom);
            #1;
            exp_rdy = (fires < k) && bus.a_valid && bus.b_valid;
            check("ready_pair", 64'({bus.a_ready, bus.b_ready}), 64'({exp_rdy, exp_rdy}));
            @(posedge clk);
            if (exp_rdy) begin
                fires++;
                last = cyc;
            end
            @(negedge clk);
            cyc++;
            got = bus.m_valid;
        end

        if (!got) begin
            check("result_timeout", 64'(0), 64'(1));
            bus.m_ready = 1'b1;
            return;
        end
        check("m_data", 64'(bus.m_data), 64'(exp));
        check("fires_before_result", 64'(fires), 64'(k));
        if (k > 0) check("latency", 64'(cyc - last), 64'(2));

        bus.a_valid = 1'b1;
        bus.b_valid = 1'b1;
        for (int s = 0; s < stall; s++) begin
            @(posedge clk);
            @(negedge clk);
            check("stall_m_valid", 64'(bus.m_valid), 64'(1));
            check("stall_m_data", 64'(bus.m_data), 64'(exp));
            check("stall_busy", 64'(busy), 64'(1));
            check("stall_a_ready", 64'(bus.a_ready), 64'(0));
        end

        // start during the output handshake must not launch a new dot product
        bus.m_ready = 1'b1;
        start = 1'b1;
        k_len = LGK'(3);
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        bus.a_valid = 1'b0;
        bus.b_valid = 1'b0;
        check("post_hs_m_valid", 64'(bus.m_valid), 64'(0));
        check("post_hs_busy", 64'(busy), 64'(0));
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst_n = 1'b0;
        start = 1'b0;
        k_len = '0;
        bus.a_data  = '0;
        bus.b_data  = '0;
        bus.a_valid = 1'b1;
        bus.b_valid = 1'b1;
        bus.m_ready = 1'b1;
        #12;
        check("rst_busy", 64'(busy), 64'(0));
        check("rst_m_valid", 64'(bus.m_valid), 64'(0));
        check("rst_m_data", 64'(bus.m_data), 64'(0));
        check("rst_a_ready", 64'(bus.a_ready), 64'(0));
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // 1..4 . 5..8 = 70, streams always valid
        va.delete(); vb.delete();
        pair(1, 5); pair(2, 6); pair(3, 7); pair(4, 8);
        run_dot(4, 100, 1'b0, 0);
        // same vectors, b_valid alternating
        run_dot(4, 100, 1'b1, 0);

        // -3*5 + 4*-2 = -23 with consumer stalled
        va.delete(); vb.delete();
        pair(-3, 5); pair(4, -2);
        run_dot(2, 100, 1'b0, 5);

        // 80000: wraps to 16'h3880 or clamps to 32767
        va.delete(); vb.delete();
        pair(200, 200); pair(200, 200);
        run_dot(2, 100, 1'b0, 0);

        // empty dot product
        va.delete(); vb.delete();
        run_dot(0, 100, 1'b0, 0);

        // reset after two of four pairs have been consumed
        va.delete(); vb.delete();
        pair(1, 5); pair(2, 6); pair(3, 7); pair(4, 8);
        bus.a_data  = W'(va[0]);
        bus.b_data  = W'(vb[0]);
        bus.a_valid = 1'b1;
        bus.b_valid = 1'b1;
        start = 1'b1;
        k_len = LGK'(4);
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        bus.a_data = W'(va[1]);
        bus.b_data = W'(vb[1]);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("abort_busy", 64'(busy), 64'(0));
        check("abort_m_valid", 64'(bus.m_valid), 64'(0));
        check("abort_m_data", 64'(bus.m_data), 64'(0));
        check("abort_a_ready", 64'(bus.a_ready), 64'(0));
        @(negedge clk);
        rst_n = 1'b1;
        bus.a_valid = 1'b0;
        bus.b_valid = 1'b0;
        @(negedge clk);
        va.delete(); vb.delete();
        pair(3, 3);
        run_dot(1, 100, 1'b0, 0);

        // random lengths, data and valid density
        for (int t = 0; t < 10; t++) begin
            int k;
            k = int'($urandom_range(20, 1));
            va.delete(); vb.delete();
            for (int i = 0; i < k; i++)
                pair(int'($urandom_range(65535)) - 32768, int'($urandom_range(65535)) - 32768);
            run_dot(k, int'($urandom_range(100, 30)), 1'b0, int'($urandom_range(3)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
